// File: rtl/mtl2_fb_mem_arbiter_if.sv
// Bundles the video burst, Avalon host and RAM port signals shared by the framebuffer arbiter.
// Modport slave is the arbiter's view; modport master is the surrounding system (video reader, host, RAM q).
// No logic lives here.
interface mtl2_fb_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17,
    parameter int LEN_W  = 10
);
    // video scan-out reader
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [LEN_W-1:0]  vid_len;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;
    logic              vid_done;
    // Avalon-MM host
    logic              h_read;
    logic              h_write;
    logic [ADDR_W-1:0] h_address;
    logic [3:0]        h_byteenable;
    logic [DATA_W-1:0] h_writedata;
    logic              h_waitrequest;
    logic [DATA_W-1:0] h_readdata;
    logic              h_readdatavalid;
    // RAM s1 port
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  vid_req, vid_addr, vid_len,
        output vid_ack, vid_rdata, vid_rvalid, vid_done,
        input  h_read, h_write, h_address, h_byteenable, h_writedata,
        output h_waitrequest, h_readdata, h_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output vid_req, vid_addr, vid_len,
        input  vid_ack, vid_rdata, vid_rvalid, vid_done,
        output h_read, h_write, h_address, h_byteenable, h_writedata,
        input  h_waitrequest, h_readdata, h_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/mtl2_fb_mem_arbiter.sv
// Arbitrates the single-port framebuffer RAM between video bursts (priority) and the Avalon host.
// Latency: host issued same cycle in IDLE, read data 1 cycle later; video data 2 cycles after vid_ack.
// Backpressure: h_waitrequest holds the host; a starvation counter forces a host slot every STARVE_LIMIT video reads.
// Ports: clk, reset (sync, active-high), bus (slave modport: video, host, RAM drive/q).
module mtl2_fb_mem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 17,
    parameter int MEM_WORDS    = 80000,
    parameter int LEN_W        = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mtl2_fb_mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VBURST = 2'd1;
    localparam logic [1:0] ST_HSLOT  = 2'd2;

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] MEM_TOP    = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
    // Counter value on the video read that completes the starvation window.
    localparam logic [CNT_W-1:0]  STARVE_HIT = CNT_W'(STARVE_LIMIT - 1);

    logic [1:0]        state, next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;   // words of the current burst not yet issued
    logic [CNT_W-1:0]  starve_cnt;

    // read tag pipe: describes the access issued in the previous cycle
    logic tag_vld, tag_host, tag_last, tag_oor;

    logic host_cmd, host_in_range;
    logic take_vid, issue_vid, issue_host, last_word;

    assign host_cmd      = bus.h_read | bus.h_write;
    assign host_in_range = bus.h_address < MEM_TOP;
    assign last_word     = remaining == LEN_W'(1);

    always_comb begin
        next_state = state;
        take_vid   = 1'b0;
        issue_vid  = 1'b0;
        issue_host = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (bus.vid_req) begin
                        take_vid   = 1'b1;
                        next_state = ST_VBURST;
                    end else if (host_cmd) begin
                        issue_host = 1'b1;
                    end
                end
                ST_VBURST: begin
                    issue_vid = 1'b1;
                    // The starvation check wins over burst completion so the
                    // host still gets its guaranteed slot on the last word.
                    if (host_cmd && starve_cnt == STARVE_HIT) begin
                        next_state = ST_HSLOT;
                    end else if (last_word) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_HSLOT: begin
                    issue_host = host_cmd;
                    next_state = (remaining == '0) ? ST_IDLE : ST_VBURST;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            starve_cnt <= '0;
            tag_vld    <= 1'b0;
            tag_host   <= 1'b0;
            tag_last   <= 1'b0;
            tag_oor    <= 1'b0;
        end else begin
            state <= next_state;

            if (take_vid) begin
                cur_addr  <= (bus.vid_addr >= MEM_TOP) ? bus.vid_addr - MEM_TOP : bus.vid_addr;
                remaining <= (bus.vid_len == '0) ? LEN_W'(1) : bus.vid_len;
            end else if (issue_vid) begin
                cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end

            if (state == ST_VBURST && host_cmd) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end

            tag_vld  <= issue_vid | (issue_host & bus.h_read);
            tag_host <= issue_host;
            tag_last <= issue_vid & last_word;
            tag_oor  <= issue_host & ~host_in_range;
        end
    end

    // video side
    assign bus.vid_ack    = take_vid;
    assign bus.vid_rdata  = bus.mem_readdata;
    assign bus.vid_rvalid = tag_vld & ~tag_host;
    assign bus.vid_done   = tag_vld & ~tag_host & tag_last;

    // host side; out-of-range reads never touch the RAM and return zero
    assign bus.h_waitrequest   = host_cmd & ~issue_host;
    assign bus.h_readdata      = tag_oor ? '0 : bus.mem_readdata;
    assign bus.h_readdatavalid = tag_vld & tag_host;

    // RAM drive
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_chipselect = issue_vid | (issue_host & host_in_range);
    assign bus.mem_write      = issue_host & bus.h_write & host_in_range;
    assign bus.mem_address    = issue_vid  ? cur_addr :
                                issue_host ? bus.h_address : '0;
    assign bus.mem_byteenable = issue_vid  ? 4'hF :
                                issue_host ? (bus.h_write ? bus.h_byteenable : 4'hF) : 4'h0;
    assign bus.mem_writedata  = (issue_host & bus.h_write) ? bus.h_writedata : '0;
endmodule

// File: tb/tb_mtl2_fb_mem_arbiter.sv
// Bench for the framebuffer arbiter: table-driven host vectors in IDLE plus burst sequences.
// Includes a 1-cycle-latency RAM model preloaded with a per-address pattern.
// Inputs change 1ns after the rising edge, outputs are sampled 2ns after it.
module tb_mtl2_fb_mem_arbiter;
    localparam int MW = 80000;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mtl2_fb_mem_arbiter_if #(.DATA_W(32), .ADDR_W(17), .LEN_W(10)) bus ();

    mtl2_fb_mem_arbiter #(
        .DATA_W(32), .ADDR_W(17), .MEM_WORDS(MW), .LEN_W(10), .STARVE_LIMIT(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 + a;
    endfunction

    // RAM model
    logic [31:0] ram [0:MW-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) ram[i] <= pat(i);
            bus.mem_readdata <= '0;
        end else if (bus.mem_clken && bus.mem_chipselect && bus.mem_address < 17'(MW)) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end
            bus.mem_readdata <= ram[bus.mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        exp_wait, exp_mw, exp_cs, exp_rv;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [12];

    // One burst, optionally with a host command presented in the ack cycle.
    task automatic burst_seq(input string nm, input int start, input int len,
                             input bit hrd, input bit hwr, input logic [16:0] haddr,
                             input logic [31:0] hwd, input logic [31:0] exp_hrd,
                             input int exp_issue, input int exp_done);
        int acks, nrv, ndone, issue_k, done_k, hrv_k, wait_cnt, base;
        logic [31:0] got_hrd;
        base = (start >= MW) ? start - MW : start;
        step();
        bus.vid_req = 1'b1; bus.vid_addr = 17'(start); bus.vid_len = 10'(len);
        bus.h_read = hrd; bus.h_write = hwr; bus.h_address = haddr;
        bus.h_writedata = hwd; bus.h_byteenable = 4'hF;
        #1;
        chk({nm, " ack"}, {31'd0, bus.vid_ack}, 32'd1);
        acks = 0; nrv = 0; ndone = 0; issue_k = -1; done_k = -1; hrv_k = -1; got_hrd = '0;
        wait_cnt = bus.h_waitrequest ? 1 : 0;
        for (int k = 1; k <= len + 12; k++) begin
            step();
            bus.vid_req = 1'b0;
            if (issue_k >= 0) begin bus.h_read = 1'b0; bus.h_write = 1'b0; end
            #1;
            if (bus.vid_ack) acks++;
            if (bus.vid_rvalid) begin
                chk($sformatf("%s data%0d", nm, nrv), bus.vid_rdata, pat((base + nrv) % MW));
                nrv++;
            end
            if (bus.vid_done) begin ndone++; if (done_k < 0) done_k = k; end
            if (bus.h_readdatavalid) begin hrv_k = k; got_hrd = bus.h_readdata; end
            if (bus.h_read || bus.h_write) begin
                if (bus.h_waitrequest) wait_cnt++;
                else if (issue_k < 0) begin
                    issue_k = k;
                    chk({nm, " mem_write at issue"}, {31'd0, bus.mem_write}, {31'd0, hwr});
                end
            end
        end
        chk({nm, " extra acks"}, 32'(acks), 32'd0);
        chk({nm, " rvalid count"}, 32'(nrv), 32'(len));
        chk({nm, " done count"}, 32'(ndone), 32'd1);
        chk({nm, " done cycle"}, 32'(done_k), 32'(exp_done));
        if (hrd || hwr) begin
            chk({nm, " host issue cycle"}, 32'(issue_k), 32'(exp_issue));
            chk({nm, " wait span"}, 32'(wait_cnt), 32'(exp_issue));
        end
        if (hrd) begin
            chk({nm, " host rvalid cycle"}, 32'(hrv_k), 32'(exp_issue + 1));
            chk({nm, " host rdata"}, got_hrd, exp_hrd);
        end
    endtask

    initial begin
        int errs;
        //            rd    wr    addr       be    wdata          wait  mw    cs    rv    rdata
        vt[0]  = '{1'b0, 1'b1, 17'd5,     4'hF, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 17'd5,     4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 17'd0,     4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678};
        vt[3]  = '{1'b0, 1'b1, 17'd6,     4'h5, 32'hAABBCCDD, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 17'd6,     4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 17'd80000, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0BB00DD};
        vt[6]  = '{1'b1, 1'b0, 17'd80001, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 17'd0,     4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 17'd79999, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 17'd6,     4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hC0DF387F};
        vt[10] = '{1'b0, 1'b0, 17'd0,     4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hC0BB00DD};
        vt[11] = '{1'b0, 1'b0, 17'd0,     4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        reset = 1'b1; preload = 1'b1;
        bus.vid_req = 1'b0; bus.vid_addr = '0; bus.vid_len = '0;
        bus.h_read = 1'b1; bus.h_write = 1'b0; bus.h_address = 17'd5;
        bus.h_byteenable = 4'hF; bus.h_writedata = '0;

        // reset state with a host read held
        repeat (3) step();
        preload = 1'b0;
        #1;
        chk("rst waitrequest", {31'd0, bus.h_waitrequest}, 32'd1);
        chk("rst vid_ack", {31'd0, bus.vid_ack}, 32'd0);
        chk("rst vid_rvalid", {31'd0, bus.vid_rvalid}, 32'd0);
        chk("rst vid_done", {31'd0, bus.vid_done}, 32'd0);
        chk("rst h_readdatavalid", {31'd0, bus.h_readdatavalid}, 32'd0);
        chk("rst chipselect", {31'd0, bus.mem_chipselect}, 32'd0);
        chk("rst mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("rst clken", {31'd0, bus.mem_clken}, 32'd1);
        bus.h_read = 1'b0;
        #1;
        chk("rst waitrequest idle", {31'd0, bus.h_waitrequest}, 32'd0);
        step();
        reset = 1'b0;

        // host-only traffic in IDLE
        for (int i = 0; i < 12; i++) begin
            step();
            bus.h_read = vt[i].rd; bus.h_write = vt[i].wr; bus.h_address = vt[i].addr;
            bus.h_byteenable = vt[i].be; bus.h_writedata = vt[i].wd;
            #1;
            chk($sformatf("v%0d waitrequest", i), {31'd0, bus.h_waitrequest}, {31'd0, vt[i].exp_wait});
            chk($sformatf("v%0d mem_write", i), {31'd0, bus.mem_write}, {31'd0, vt[i].exp_mw});
            chk($sformatf("v%0d chipselect", i), {31'd0, bus.mem_chipselect}, {31'd0, vt[i].exp_cs});
            chk($sformatf("v%0d h_rvalid", i), {31'd0, bus.h_readdatavalid}, {31'd0, vt[i].exp_rv});
            chk($sformatf("v%0d vid_rvalid", i), {31'd0, bus.vid_rvalid}, 32'd0);
            if (vt[i].exp_rv) chk($sformatf("v%0d h_rdata", i), bus.h_readdata, vt[i].exp_rd);
        end

        // bursts
        burst_seq("b100",    100,   16, 1'b0, 1'b0, 17'd0, 32'h0,        32'h0,        0, 17);
        burst_seq("starve",  200,   64, 1'b1, 1'b0, 17'd5, 32'h0,        32'h12345678, 9, 66);
        burst_seq("wrap",    79998,  4, 1'b0, 1'b0, 17'd0, 32'h0,        32'h0,        0, 5);
        burst_seq("capred",  80002,  2, 1'b0, 1'b0, 17'd0, 32'h0,        32'h0,        0, 3);
        burst_seq("simul",   500,   20, 1'b0, 1'b1, 17'd7, 32'hDEADBEEF, 32'h0,        9, 22);

        step();
        bus.h_read = 1'b1; bus.h_write = 1'b0; bus.h_address = 17'd7;
        #1;
        chk("rd7 waitrequest", {31'd0, bus.h_waitrequest}, 32'd0);
        step();
        bus.h_read = 1'b0;
        #1;
        chk("rd7 rvalid", {31'd0, bus.h_readdatavalid}, 32'd1);
        chk("rd7 rdata", bus.h_readdata, 32'hDEADBEEF);

        // reset three cycles into a len-32 burst
        step();
        bus.vid_req = 1'b1; bus.vid_addr = 17'd300; bus.vid_len = 10'd32;
        #1;
        chk("abort ack", {31'd0, bus.vid_ack}, 32'd1);
        step(); bus.vid_req = 1'b0;
        step();
        step(); reset = 1'b1;
        #1;
        chk("abort cs in reset", {31'd0, bus.mem_chipselect}, 32'd0);
        step(); reset = 1'b0;
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            #1;
            if (bus.vid_rvalid || bus.vid_done || bus.mem_chipselect) errs++;
        end
        chk("abort quiet after reset", 32'(errs), 32'd0);
        burst_seq("after_rst", 400, 8, 1'b0, 1'b0, 17'd0, 32'h0, 32'h0, 0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mtl2_fb_mem_arbiter.md
# mtl2_fb_mem_arbiter

Arbiter sharing the single-port 32-bit on-chip framebuffer RAM (80000 words, 17-bit word address, 1-cycle read latency) between the MTL2 display scan-out reader and the Avalon-MM host (Nios painter). Video bursts get priority. A starvation counter guarantees the host a slot during long bursts. Sits between both masters and the RAM's s1 port.

## Interface
- DATA_W, 32, data/word width
- ADDR_W, 17, word address width
- MEM_WORDS, 80000, valid word count; addresses >= MEM_WORDS are out of range
- LEN_W, 10, video burst length width (1..1023 words; 0 treated as 1)
- STARVE_LIMIT, 8, consecutive video cycles before a pending host access is forced in (>=1)
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- vid_req  in  1  burst request (level, held until vid_ack)
- vid_addr  in  ADDR_W  burst start word address
- vid_len  in  LEN_W  burst length in words
- vid_ack  out  1  1-cycle pulse: burst accepted, addr/len captured
- vid_rdata  out  DATA_W  read data to video FIFO
- vid_rvalid  out  1  vid_rdata valid this cycle
- vid_done  out  1  1-cycle pulse with the last vid_rvalid of a burst
- h_read, h_write  in  1  Avalon host commands (never both)
- h_address  in  ADDR_W  host word address
- h_byteenable  in  4  host byte lanes
- h_writedata  in  DATA_W  host write data
- h_waitrequest  out  1  host must hold command while high
- h_readdata  out  DATA_W  host read data
- h_readdatavalid  out  1  h_readdata valid this cycle
- mem_address  out  ADDR_W, mem_byteenable  out  4, mem_chipselect  out  1, mem_write  out  1, mem_writedata  out  DATA_W, mem_clken  out  1  RAM port drive
- mem_readdata  in  DATA_W  RAM q, valid one cycle after the read address is issued

## Operation
- States: IDLE, VBURST, HSLOT. Exactly one RAM access per cycle max; mem_clken constant 1.
- IDLE: vid_req -> capture addr/len, vid_ack, next VBURST (video wins simultaneous request). Else host command -> issue it this cycle, h_waitrequest low, stay IDLE.
- VBURST: each cycle issue read at current address, increment; address wraps MEM_WORDS-1 -> 0. Counter starve_cnt increments while host command pending, clears otherwise. starve_cnt == STARVE_LIMIT -> next cycle HSLOT (burst paused, no address advance). After last word issued -> IDLE.
- HSLOT: issue host command (h_waitrequest low), clear starve_cnt, return VBURST (or IDLE if burst already complete).
- h_waitrequest = 1 whenever a host command is present and not issued this cycle; 0 when no command.
- Read tag pipeline: 1-bit owner + valid registered at issue; next cycle route mem_readdata to owner with its valid. Both data outputs driven from mem_readdata directly (non-selected valid low).
- Host out-of-range: write accepted, no RAM write (mem_write low); read accepted, h_readdatavalid next cycle with h_readdata = 0.
- Video addresses always in range (wrap); vid_addr >= MEM_WORDS at capture reduced by MEM_WORDS.
- mem_write = issued host write; mem_chipselect = any access issued; mem_byteenable = 4'hF for reads.

## Timing
- Reset: state IDLE, counters 0, tag pipe cleared; all outputs 0 except h_waitrequest = h_read|h_write (combinational), mem_clken = 1. Reset mid-burst aborts it; no rvalid/done in the cycle after reset.
- vid_ack in cycle T (IDLE); first read issued T+1; first vid_rvalid T+2; burst of L with no host: vid_rvalid T+2..T+L+1, vid_done at T+L+1.
- Host in IDLE: read issued same cycle as presented (waitrequest low), h_readdatavalid next cycle; zero wait.
- Host during burst: worst-case wait STARVE_LIMIT+1 cycles; each HSLOT stretches burst by 1 cycle.
- Next burst may be acked the cycle after the last read is issued (overlaps last data return).

## Test plan
- Reset, then host write 0x12345678 to addr 5 with be=4'hF, read addr 5 -> waitrequest never high, h_readdatavalid 1 cycle after read with 0x12345678.
- vid burst addr 100 len 16, idle host -> vid_ack once, 16 consecutive vid_rvalid starting 2 cycles after ack, vid_done with 16th, data matches preload.
- Host read held from burst start, len 64, STARVE_LIMIT 8 -> host issued after 8 video reads, 1 waitrequest-high span of 9 cycles, burst finishes in 65 issue cycles with correct in-order data.
- Burst addr 79998 len 4 -> reads 79998, 79999, 0, 1.
- Host write to 80000 then read 80001 -> no mem_write pulse, readdata 0; simultaneous vid_req and h_write in IDLE -> video acked first, host issued after STARVE_LIMIT.
- Assert reset 3 cycles into len-32 burst -> no vid_rvalid/vid_done after reset cycle, next burst runs normally.
